// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with configurable word length, parity and stop bits.
// Bits are sampled mid-bit by counting sample_tick pulses from the detected start edge.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_error,
  output logic                 stop_error,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic             ODD_SEL   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               r_state, w_state_next;
  logic                 r_rxd_meta, r_rxd_sync;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next;
  logic [IDX_W-1:0]     r_idx, w_idx_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic [DATA_BITS-1:0] r_data, w_data_next;
  logic                 r_stop_idx, w_stop_idx_next;
  logic                 r_par_pend, w_par_pend_next;
  logic                 r_stop_pend, w_stop_pend_next;
  logic                 r_valid, w_valid_next;
  logic                 r_par_err, w_par_err_next;
  logic                 r_stop_err, w_stop_err_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxd_meta  <= 1'b1;
      r_rxd_sync  <= 1'b1;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_stop_idx  <= 1'b0;
      r_par_pend  <= 1'b0;
      r_stop_pend <= 1'b0;
      r_valid     <= 1'b0;
      r_par_err   <= 1'b0;
      r_stop_err  <= 1'b0;
    end else begin
      r_rxd_meta  <= RXD;
      r_rxd_sync  <= r_rxd_meta;
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_idx       <= w_idx_next;
      r_shift     <= w_shift_next;
      r_data      <= w_data_next;
      r_stop_idx  <= w_stop_idx_next;
      r_par_pend  <= w_par_pend_next;
      r_stop_pend <= w_stop_pend_next;
      r_valid     <= w_valid_next;
      r_par_err   <= w_par_err_next;
      r_stop_err  <= w_stop_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_idx_next       = r_idx;
    w_shift_next     = r_shift;
    w_data_next      = r_data;
    w_stop_idx_next  = r_stop_idx;
    w_par_pend_next  = r_par_pend;
    w_stop_pend_next = r_stop_pend;
    w_valid_next     = 1'b0;
    w_par_err_next   = r_par_err;
    w_stop_err_next  = r_stop_err;

    if (sample_tick) begin
      case (r_state)
        IDLE: begin
          if (!r_rxd_sync) begin
            w_state_next     = START;
            w_cnt_next       = '0;
            w_idx_next       = '0;
            w_stop_idx_next  = 1'b0;
            w_par_pend_next  = 1'b0;
            w_stop_pend_next = 1'b0;
          end
        end
        // Line must still be low at mid start bit, otherwise treat as a glitch.
        START: begin
          if (r_cnt == HALF_CNT) begin
            w_cnt_next   = '0;
            w_state_next = r_rxd_sync ? IDLE : DATA;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (r_cnt == FULL_CNT) begin
            w_cnt_next          = '0;
            w_shift_next[r_idx] = r_rxd_sync;
            w_idx_next          = r_idx + IDX_W'(1);
            if (r_idx == LAST_IDX) begin
              w_state_next = (PARITY_EN != 0) ? PARITY : STOP;
            end
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
        PARITY: begin
          if (r_cnt == FULL_CNT) begin
            w_cnt_next      = '0;
            w_par_pend_next = r_rxd_sync ^ (^r_shift) ^ ODD_SEL;
            w_state_next    = STOP;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
        // Leaving at mid stop bit lets an immediately following start bit be caught.
        STOP: begin
          if (r_cnt == FULL_CNT) begin
            w_cnt_next = '0;
            if (r_stop_idx == LAST_STOP) begin
              w_data_next     = r_shift;
              w_par_err_next  = r_par_pend;
              w_stop_err_next = r_stop_pend | ~r_rxd_sync;
              w_valid_next    = 1'b1;
              w_state_next    = IDLE;
            end else begin
              w_stop_pend_next = r_stop_pend | ~r_rxd_sync;
              w_stop_idx_next  = r_stop_idx + 1'b1;
            end
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign parity_error = r_par_err;
  assign stop_error   = r_stop_err;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: default 8E1 instance plus a 7O2 instance
// with OVERSAMPLE=8 and a tick every third clock.
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd1, rxd2;
  logic       tick2;
  logic [1:0] tick_cnt = 2'd0;

  logic [7:0] rx_data1;
  logic       rx_valid1, perr1, serr1, busy1;
  logic [6:0] rx_data2;
  logic       rx_valid2, perr2, serr2, busy2;

  int n_checks = 0;
  int n_pass   = 0;

  logic [9:0] q1[$];
  logic [8:0] q2[$];

  always #5 clk = ~clk;

  always @(posedge clk) tick_cnt <= (tick_cnt == 2'd2) ? 2'd0 : tick_cnt + 2'd1;
  assign tick2 = (tick_cnt == 2'd2);

  uart_rx_param u_dut1 (
    .clk(clk), .reset(reset), .sample_tick(1'b1), .RXD(rxd1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .parity_error(perr1),
    .stop_error(serr1), .busy(busy1)
  );

  uart_rx_param #(
    .DATA_BITS(7), .OVERSAMPLE(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
  ) u_dut2 (
    .clk(clk), .reset(reset), .sample_tick(tick2), .RXD(rxd2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .parity_error(perr2),
    .stop_error(serr2), .busy(busy2)
  );

  // Every received frame is logged as {parity_error, stop_error, data}.
  always @(negedge clk) begin
    if (rx_valid1) begin
      q1.push_back({perr1, serr1, rx_data1});
      $display("rx1 data=%h perr=%b serr=%b", rx_data1, perr1, serr1);
    end
    if (rx_valid2) begin
      q2.push_back({perr2, serr2, rx_data2});
      $display("rx2 data=%h perr=%b serr=%b", rx_data2, perr2, serr2);
    end
  end

  // Reference model: errors follow from the bits put on the line.
  function automatic logic [9:0] model1(logic [7:0] d, bit par, bit stp);
    bit want_par = bit'($countones(d) % 2);
    return {par != want_par, !stp, d};
  endfunction

  function automatic logic [8:0] model2(logic [6:0] d, bit par, bit stp_a, bit stp_b);
    bit want_par = !bit'($countones(d) % 2);
    return {par != want_par, !(stp_a && stp_b), d};
  endfunction

  task automatic drive1(input bit v);
    rxd1 = v;
    repeat (16) @(negedge clk);
  endtask

  task automatic idle1(input int nbits);
    for (int i = 0; i < nbits; i++) drive1(1'b1);
  endtask

  task automatic send1(input logic [7:0] d, input bit par, input bit stp);
    drive1(1'b0);
    for (int i = 0; i < 8; i++) drive1(d[i]);
    drive1(par);
    drive1(stp);
  endtask

  task automatic drive2(input bit v);
    rxd2 = v;
    repeat (24) @(negedge clk);
  endtask

  task automatic send2(input logic [6:0] d, input bit par, input bit sa, input bit sb);
    drive2(1'b0);
    for (int i = 0; i < 7; i++) drive2(d[i]);
    drive2(par);
    drive2(sa);
    drive2(sb);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rxd1  = 1'b1;
    rxd2  = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({rx_data1, rx_valid1, perr1, serr1, busy1} !== 12'h0)
      $display("FAIL reset_dut1 got %h required 000", {rx_data1, rx_valid1, perr1, serr1, busy1});
    else n_pass++;
    n_checks++;
    if ({rx_data2, rx_valid2, perr2, serr2, busy2} !== 11'h0)
      $display("FAIL reset_dut2 got %h required 000", {rx_data2, rx_valid2, perr2, serr2, busy2});
    else n_pass++;
    reset = 1'b0;
    idle1(2);
  endtask

  task automatic test_good();
    logic [9:0] got;
    q1.delete();
    send1(8'hA5, 1'b0, 1'b1);
    idle1(2);
    n_checks++;
    if (q1.size() !== 1) $display("FAIL good_count got %0d required 1", q1.size());
    else n_pass++;
    if (q1.size() > 0) begin
      got = q1.pop_front();
      n_checks++;
      if (got !== 10'h0A5) $display("FAIL good_frame got %h required 0a5", got);
      else n_pass++;
    end
    n_checks++;
    if ({perr1, serr1, rx_data1} !== 10'h0A5)
      $display("FAIL good_hold got %h required 0a5", {perr1, serr1, rx_data1});
    else n_pass++;
  endtask

  task automatic test_parity_err();
    logic [9:0] got;
    q1.delete();
    send1(8'hA5, 1'b1, 1'b1);
    idle1(1);
    n_checks++;
    if (q1.size() !== 1) $display("FAIL parity_count got %0d required 1", q1.size());
    else n_pass++;
    if (q1.size() > 0) begin
      got = q1.pop_front();
      n_checks++;
      if (got !== 10'h2A5) $display("FAIL parity_frame got %h required 2a5", got);
      else n_pass++;
    end
  endtask

  task automatic test_stop_err();
    logic [9:0] got;
    q1.delete();
    send1(8'h3C, 1'b0, 1'b0);
    idle1(1);
    n_checks++;
    if (q1.size() !== 1) $display("FAIL stop_count got %0d required 1", q1.size());
    else n_pass++;
    if (q1.size() > 0) begin
      got = q1.pop_front();
      n_checks++;
      if (got !== 10'h13C) $display("FAIL stop_frame got %h required 13c", got);
      else n_pass++;
    end
    send1(8'h01, 1'b1, 1'b1);
    idle1(1);
    n_checks++;
    if (q1.size() !== 1) $display("FAIL stop_clear_count got %0d required 1", q1.size());
    else n_pass++;
    if (q1.size() > 0) begin
      got = q1.pop_front();
      n_checks++;
      if (got !== 10'h001) $display("FAIL stop_clear_frame got %h required 001", got);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    int waited;
    q1.delete();
    rxd1 = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (busy1 !== 1'b1) $display("FAIL glitch_busy_high got %b required 1", busy1);
    else n_pass++;
    rxd1 = 1'b1;
    waited = 0;
    while (busy1 !== 1'b0 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (busy1 !== 1'b0) $display("FAIL glitch_busy_low got %b required 0 within 8 ticks", busy1);
    else n_pass++;
    idle1(2);
    n_checks++;
    if (q1.size() !== 0) $display("FAIL glitch_no_valid got %0d frames required 0", q1.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [9:0] got;
    q1.delete();
    send1(8'h00, 1'b0, 1'b1);
    send1(8'hFF, 1'b0, 1'b1);
    idle1(1);
    n_checks++;
    if (q1.size() !== 2) $display("FAIL b2b_count got %0d required 2", q1.size());
    else n_pass++;
    if (q1.size() == 2) begin
      got = q1.pop_front();
      n_checks++;
      if (got !== 10'h000) $display("FAIL b2b_first got %h required 000", got);
      else n_pass++;
      got = q1.pop_front();
      n_checks++;
      if (got !== 10'h0FF) $display("FAIL b2b_second got %h required 0ff", got);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [9:0] got, exp;
    logic [7:0] d;
    bit         par, stp;
    int         gap;
    q1.delete();
    for (int n = 0; n < 20; n++) begin
      d   = 8'($urandom);
      par = ($urandom_range(0, 3) == 0) ? !bit'($countones(d) % 2) : bit'($countones(d) % 2);
      stp = ($urandom_range(0, 4) != 0);
      gap = stp ? $urandom_range(0, 2) : $urandom_range(1, 2);
      exp = model1(d, par, stp);
      send1(d, par, stp);
      idle1(gap);
      n_checks++;
      if (q1.size() !== 1) begin
        $display("FAIL rand_count[%0d] got %0d required 1", n, q1.size());
        q1.delete();
      end else begin
        n_pass++;
        got = q1.pop_front();
        n_checks++;
        if (got !== exp) $display("FAIL rand_frame[%0d] got %h required %h", n, got, exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [9:0]  got;
    logic [7:0]  d = 8'hC3;
    q1.delete();
    send1(8'hE7, 1'b1, 1'b0);
    idle1(2);
    q1.delete();
    drive1(1'b0);
    for (int i = 0; i < 3; i++) drive1(d[i]);
    rxd1 = d[3];
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({rx_data1, rx_valid1, perr1, serr1, busy1} !== 12'h0)
      $display("FAIL midreset_outputs got %h required 000", {rx_data1, rx_valid1, perr1, serr1, busy1});
    else n_pass++;
    rxd1 = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle1(2);
    n_checks++;
    if (q1.size() !== 0) $display("FAIL midreset_no_valid got %0d frames required 0", q1.size());
    else n_pass++;
    send1(8'h5A, 1'b0, 1'b1);
    idle1(1);
    n_checks++;
    if (q1.size() !== 1) $display("FAIL midreset_next_count got %0d required 1", q1.size());
    else n_pass++;
    if (q1.size() > 0) begin
      got = q1.pop_front();
      n_checks++;
      if (got !== 10'h05A) $display("FAIL midreset_next_frame got %h required 05a", got);
      else n_pass++;
    end
  endtask

  task automatic test_cfg2();
    logic [8:0] got, exp;
    logic [6:0] d;
    bit         par, sa, sb;
    q2.delete();
    send2(7'h55, 1'b1, 1'b1, 1'b1);
    drive2(1'b1);
    n_checks++;
    if (q2.size() !== 1) $display("FAIL cfg2_count got %0d required 1", q2.size());
    else n_pass++;
    if (q2.size() > 0) begin
      got = q2.pop_front();
      n_checks++;
      if (got !== 9'h055) $display("FAIL cfg2_frame got %h required 055", got);
      else n_pass++;
    end
    for (int n = 0; n < 5; n++) begin
      d   = 7'($urandom);
      par = bit'($urandom_range(0, 1));
      sa  = ($urandom_range(0, 3) != 0);
      sb  = ($urandom_range(0, 3) != 0);
      exp = model2(d, par, sa, sb);
      send2(d, par, sa, sb);
      drive2(1'b1);
      n_checks++;
      if (q2.size() !== 1) begin
        $display("FAIL cfg2_rand_count[%0d] got %0d required 1", n, q2.size());
        q2.delete();
      end else begin
        n_pass++;
        got = q2.pop_front();
        n_checks++;
        if (got !== exp) $display("FAIL cfg2_rand_frame[%0d] got %h required %h", n, got, exp);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_parity_err();
    test_stop_err();
    test_glitch();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    test_cfg2();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
